// File: rtl/clock_counter_pkg.sv
// Shared constants for the clock counter: FSM encoding, rate codes, command bits.
package clock_counter_pkg;

  localparam int unsigned ST_W = 2;
  localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [ST_W-1:0] ST_RUN   = 2'd1;
  localparam logic [ST_W-1:0] ST_PAUSE = 2'd2;

  localparam int unsigned RATE_W = 2;
  localparam logic [RATE_W-1:0] RATE_1HZ = 2'b00;
  localparam logic [RATE_W-1:0] RATE_2HZ = 2'b01;
  localparam logic [RATE_W-1:0] RATE_4HZ = 2'b10;
  localparam logic [RATE_W-1:0] RATE_8HZ = 2'b11;

  localparam int unsigned CMD_W     = 4;
  localparam int unsigned CMD_START = 0;
  localparam int unsigned CMD_STOP  = 1;
  localparam int unsigned CMD_STEP  = 2;
  localparam int unsigned CMD_CLEAR = 3;

  // Period in clock cycles for a rate code; rates are 1/2/4/8 Hz so it is a shift.
  function automatic int unsigned rate_period(input int unsigned clk_hz,
                                              input logic [RATE_W-1:0] rate);
    return clk_hz >> rate;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw active-low button -> 2-flop sync -> debounced level -> one-cycle press pulse.
// After reset the debouncer stays "released" and is only armed once the
// synchronized input has been seen released for DB_CYCLES cycles, so a button
// held through reset never produces a command.
module btn_debounce #(
  parameter int unsigned DB_CYCLES = 120000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);

  localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;   // debounced level, 1 = released
  logic             armed_q, armed_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             press_q, press_d;

  // Next-state: synchronizer shift, stability counting, arming, press edge.
  always_comb begin
    sync1_d = btn_n;
    sync2_d = sync1_q;
    level_d = level_q;
    armed_d = armed_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (!armed_q) begin
      if (sync2_q) begin
        if (cnt_q == CNT_LAST) armed_d = 1'b1;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end
    end else if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) level_d = sync2_q;
      else                   cnt_d   = cnt_q + CNT_W'(1);
    end
    press_d = level_q & ~level_d;
  end

  // State registers, reset to the released/idle condition.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      armed_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/clock_counter_ctrl.sv
// 4-bit LED counter with START/STOP/STEP/CLEAR buttons and selectable 1-8 Hz rate.
module clock_counter_ctrl #(
  parameter int unsigned CLK_HZ    = 12000000,
  parameter int unsigned DB_CYCLES = 120000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pmod_0,
  input  logic       pmod_1,
  input  logic       pmod_2,
  input  logic       pmod_3,
  input  logic [1:0] rate_sel,
  output logic [3:0] led,
  output logic       running,
  output logic       tick,
  output logic       wrap
);

  import clock_counter_pkg::*;

  localparam int unsigned DIV_W = $clog2(CLK_HZ);
  localparam int unsigned LED_W = 4;

  logic [CMD_W-1:0]  cmd;
  logic [ST_W-1:0]   state_q,   state_d;
  logic [LED_W-1:0]  led_q,     led_d;
  logic [DIV_W-1:0]  div_q,     div_d;
  logic [RATE_W-1:0] rate_q,    rate_d;
  logic              running_q, running_d;
  logic              tick_q,    tick_d;
  logic              wrap_q,    wrap_d;
  logic [RATE_W-1:0] eff_rate;
  logic [DIV_W-1:0]  div_last;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_btn_start (
    .clk(clk), .rst(rst), .btn_n(pmod_0), .press(cmd[CMD_START]));
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_btn_stop (
    .clk(clk), .rst(rst), .btn_n(pmod_1), .press(cmd[CMD_STOP]));
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_btn_step (
    .clk(clk), .rst(rst), .btn_n(pmod_2), .press(cmd[CMD_STEP]));
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_btn_clear (
    .clk(clk), .rst(rst), .btn_n(pmod_3), .press(cmd[CMD_CLEAR]));

  // Command decode (CLEAR > STOP > START > STEP), divider and LED update.
  always_comb begin
    state_d   = state_q;
    led_d     = led_q;
    div_d     = div_q;
    rate_d    = rate_q;
    tick_d    = 1'b0;
    wrap_d    = 1'b0;
    running_d = 1'b0;
    // rate_sel only matters at the start of a period
    eff_rate  = (div_q == '0) ? rate_sel : rate_q;
    div_last  = DIV_W'(rate_period(CLK_HZ, eff_rate) - 1);

    if (cmd[CMD_CLEAR]) begin
      state_d = ST_IDLE;
      led_d   = '0;
      div_d   = '0;
    end else if (cmd[CMD_STOP]) begin
      if (state_q == ST_RUN) state_d = ST_PAUSE;
    end else if (cmd[CMD_START]) begin
      if (state_q != ST_RUN) state_d = ST_RUN;
    end else if (cmd[CMD_STEP]) begin
      if (state_q == ST_IDLE) begin
        led_d   = LED_W'(1);
        state_d = ST_PAUSE;
      end else if (state_q == ST_PAUSE) begin
        led_d  = led_q + LED_W'(1);
        wrap_d = (led_q == '1);
      end
    end

    // The edge that enters RUN is itself a counting edge, so a resume from a
    // held divider continues exactly where it stopped.
    if (state_d == ST_RUN) begin
      if (div_q == '0) rate_d = rate_sel;
      if (div_q == div_last) begin
        div_d  = '0;
        led_d  = led_q + LED_W'(1);
        tick_d = 1'b1;
        wrap_d = (led_q == '1);
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end

    running_d = (state_d == ST_RUN);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      led_q     <= '0;
      div_q     <= '0;
      rate_q    <= RATE_1HZ;
      running_q <= 1'b0;
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      led_q     <= led_d;
      div_q     <= div_d;
      rate_q    <= rate_d;
      running_q <= running_d;
      tick_q    <= tick_d;
      wrap_q    <= wrap_d;
    end
  end

  assign led     = led_q;
  assign running = running_q;
  assign tick    = tick_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_clock_counter_ctrl.sv
// Directed bench for clock_counter_ctrl with CLK_HZ=80, DB_CYCLES=4.
// A button driven low in cycle t gives a command in cycle t+6 whose effect is
// visible on the registered outputs in cycle t+7.
module tb_clock_counter_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       pmod_0, pmod_1, pmod_2, pmod_3;
  logic [1:0] rate_sel;
  logic [3:0] led;
  logic       running, tick, wrap;

  int checks = 0;
  int errors = 0;
  int t      = 0;

  clock_counter_ctrl #(.CLK_HZ(80), .DB_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .pmod_0(pmod_0), .pmod_1(pmod_1), .pmod_2(pmod_2), .pmod_3(pmod_3),
    .rate_sel(rate_sel),
    .led(led), .running(running), .tick(tick), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed=%0d expected=%0d", tag, t, obs, exp);
    end
  endtask

  // Advance to cycle 'target' (1 time unit after its rising edge).
  task automatic go_to(input int target);
    if (target > t) begin
      repeat (target - t) @(posedge clk);
      #1;
      t = target;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rate_sel = 2'b00;
    pmod_0 = 1'b1; pmod_1 = 1'b1; pmod_2 = 1'b1; pmod_3 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_led", 32'(led), 0);
    chk("rst_running", 32'(running), 0);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_wrap", 32'(wrap), 0);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    t = 0;

    // START at 1 Hz: tick 80 cycles after command cycle 6
    pmod_0 = 1'b0;
    go_to(7);   chk("start_running", 32'(running), 1); chk("start_led", 32'(led), 0);
    pmod_0 = 1'b1;
    go_to(85);  chk("t1_pre_tick", 32'(tick), 0); chk("t1_pre_led", 32'(led), 0);
    go_to(86);  chk("t1_tick", 32'(tick), 1); chk("t1_led", 32'(led), 1);
    go_to(87);  chk("t1_tick_pulse", 32'(tick), 0);
    go_to(165); chk("t2_pre_tick", 32'(tick), 0);
    go_to(166); chk("t2_tick", 32'(tick), 1); chk("t2_led", 32'(led), 2);

    // 8 Hz period, then switch to 1 Hz mid-period
    rate_sel = 2'b11;
    go_to(175); chk("r8_pre_tick", 32'(tick), 0);
    go_to(176); chk("r8_tick", 32'(tick), 1); chk("r8_led", 32'(led), 3);
    go_to(180); rate_sel = 2'b00;
    go_to(185); chk("mid_pre_tick", 32'(tick), 0);
    go_to(186); chk("mid_tick", 32'(tick), 1); chk("mid_led", 32'(led), 4);
    go_to(196); chk("slow_no_tick", 32'(tick), 0);
    go_to(265); chk("slow_pre_tick", 32'(tick), 0);
    go_to(266); chk("slow_tick", 32'(tick), 1); chk("slow_led", 32'(led), 5);

    // STOP at divider=40, long pause, resume: tick 40 cycles after START cmd
    go_to(300); pmod_1 = 1'b0;
    go_to(307); chk("stop_running", 32'(running), 0); chk("stop_led", 32'(led), 5);
    pmod_1 = 1'b1;
    go_to(800); chk("pause_led", 32'(led), 5); chk("pause_tick", 32'(tick), 0);
    go_to(807); pmod_0 = 1'b0;
    go_to(814); chk("resume_running", 32'(running), 1); chk("resume_led", 32'(led), 5);
    pmod_0 = 1'b1;
    go_to(852); chk("resume_pre_tick", 32'(tick), 0);
    go_to(853); chk("resume_tick", 32'(tick), 1); chk("resume_led6", 32'(led), 6);

    // STOP coinciding with divider==N-1 wins; resume ticks one cycle later
    go_to(926); pmod_1 = 1'b0;
    go_to(932); chk("edge_pre_running", 32'(running), 1);
    go_to(933); chk("edge_stop_tick", 32'(tick), 0); chk("edge_stop_led", 32'(led), 6);
    chk("edge_stop_running", 32'(running), 0);
    pmod_1 = 1'b1;
    go_to(940); pmod_0 = 1'b0;
    go_to(947); chk("edge_resume_tick", 32'(tick), 1); chk("edge_resume_led", 32'(led), 7);
    pmod_0 = 1'b1;

    // STOP, then STEP up to 15 and wrap
    go_to(950); pmod_1 = 1'b0;
    go_to(957); chk("stop2_running", 32'(running), 0); chk("stop2_led", 32'(led), 7);
    pmod_1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      go_to(970 + 16 * i); pmod_2 = 1'b0;
      go_to(977 + 16 * i);
      chk("step_led", 32'(led), 32'(8 + i));
      chk("step_wrap", 32'(wrap), 0);
      pmod_2 = 1'b1;
    end
    go_to(1098); pmod_2 = 1'b0;
    go_to(1105); chk("stepwrap_led", 32'(led), 0); chk("stepwrap_wrap", 32'(wrap), 1);
    chk("stepwrap_tick", 32'(tick), 0);
    pmod_2 = 1'b1;
    go_to(1106); chk("stepwrap_pulse", 32'(wrap), 0);

    // RUN, then STOP+START+CLEAR together
    go_to(1110); pmod_0 = 1'b0;
    go_to(1117); chk("run3_running", 32'(running), 1);
    pmod_0 = 1'b1;
    go_to(1186); chk("run3_pre_tick", 32'(tick), 0);
    go_to(1187); chk("run3_tick", 32'(tick), 1); chk("run3_led", 32'(led), 1);
    go_to(1190); pmod_0 = 1'b0; pmod_1 = 1'b0; pmod_3 = 1'b0;
    go_to(1197); chk("clr_led", 32'(led), 0); chk("clr_running", 32'(running), 0);
    chk("clr_tick", 32'(tick), 0);
    pmod_0 = 1'b1; pmod_1 = 1'b1; pmod_3 = 1'b1;
    go_to(1300); chk("idle_led", 32'(led), 0); chk("idle_running", 32'(running), 0);

    // STEP from IDLE gives led=1; START then counts a full period from divider 0
    pmod_2 = 1'b0;
    go_to(1307); chk("idle_step_led", 32'(led), 1); chk("idle_step_running", 32'(running), 0);
    pmod_2 = 1'b1;
    go_to(1320); pmod_0 = 1'b0;
    go_to(1327); chk("run4_running", 32'(running), 1);
    pmod_0 = 1'b1;
    go_to(1405); chk("run4_pre_tick", 32'(tick), 0);
    go_to(1406); chk("run4_tick", 32'(tick), 1); chk("run4_led", 32'(led), 2);

    // Pause, then bounce STEP for 20 cycles before holding it low
    go_to(1410); pmod_1 = 1'b0;
    go_to(1417); chk("stop4_running", 32'(running), 0); chk("stop4_led", 32'(led), 2);
    pmod_1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      go_to(1430 + 2 * i);
      pmod_2 = (i % 2 == 0) ? 1'b0 : 1'b1;
    end
    go_to(1449); chk("bounce_no_cmd", 32'(led), 2);
    go_to(1450); pmod_2 = 1'b0;
    go_to(1456); chk("bounce_pre_cmd", 32'(led), 2);
    go_to(1457); chk("bounce_one_cmd", 32'(led), 3);
    go_to(1500); chk("hold_no_repeat", 32'(led), 3);

    // Reset with STEP still held: no command after reset release
    rst = 1'b1;
    go_to(1501); chk("rst2_led", 32'(led), 0); chk("rst2_running", 32'(running), 0);
    go_to(1503); rst = 1'b0;
    go_to(1525); chk("rst_held_no_cmd", 32'(led), 0);
    go_to(1530); chk("rst_held_no_cmd2", 32'(led), 0);
    pmod_2 = 1'b1;
    go_to(1545); pmod_2 = 1'b0;
    go_to(1551); chk("post_rst_pre_step", 32'(led), 0);
    go_to(1552); chk("post_rst_step", 32'(led), 1);
    pmod_2 = 1'b1;
    go_to(1560);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_counter_ctrl.md
CLOCK_COUNTER_CTRL -- requirements
Module: clock_counter_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 12000000, input clock frequency in Hz; SHALL be a multiple of 8.
REQ-002 Parameter DB_CYCLES, default 120000, button stable time in cycles (10 ms at 12 MHz).
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 pmod_0  in  1  START button, raw, active-low.
REQ-006 pmod_1  in  1  STOP button, raw, active-low.
REQ-007 pmod_2  in  1  STEP button, raw, active-low.
REQ-008 pmod_3  in  1  CLEAR button, raw, active-low.
REQ-009 rate_sel  in  2  count rate: 00=1 Hz, 01=2 Hz, 10=4 Hz, 11=8 Hz.
REQ-010 led  out  4  current count value.
REQ-011 running  out  1  high while state is RUN.
REQ-012 tick  out  1  one-cycle pulse coincident with each rate-driven led update.
REQ-013 wrap  out  1  one-cycle pulse coincident with any led update 15->0.

Function
REQ-014 Each button SHALL pass a 2-flop synchronizer, then a debouncer that changes its output only after the synchronized input holds a new level for DB_CYCLES consecutive cycles.
REQ-015 A command SHALL be one cycle of a debounced press edge (released->pressed); holding a button SHALL NOT repeat it.
REQ-016 States: IDLE, RUN, PAUSE; reset state IDLE.
REQ-017 IDLE: START->RUN; STEP->led=1, PAUSE; STOP ignored.
REQ-018 RUN: STOP->PAUSE; START, STEP ignored.
REQ-019 PAUSE: START->RUN; STEP->led+1, stay PAUSE; STOP ignored.
REQ-020 CLEAR from any state: led=0, divider=0, state IDLE.
REQ-021 Simultaneous commands: priority CLEAR > STOP > START > STEP; only the highest-priority command acts.
REQ-022 Period N = CLK_HZ / rate; divider counts 0..N-1 only in RUN and holds its value in PAUSE.
REQ-023 In RUN, at the edge where divider==N-1: divider->0, led->led+1 (mod 16), tick=1 for the following cycle.
REQ-024 First tick after entering RUN from IDLE SHALL come exactly N cycles after the START command cycle.
REQ-025 rate_sel SHALL be sampled only when divider is 0 in RUN; a mid-period change takes effect from the next period.
REQ-026 led increment SHALL wrap 15->0 and assert wrap the same cycle; STEP-caused wraps assert wrap but not tick.
REQ-027 STOP on the same edge as divider==N-1 SHALL win: no increment, divider holds N-1, first tick after resume comes 1 cycle later.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 rst SHALL set: state IDLE, led=0, divider=0, running=0, tick=0, wrap=0, sampled rate=1 Hz.
REQ-030 rst SHALL set synchronizers and debouncers to "released", so the first cycles after reset produce no command even with a button held.
REQ-031 rst SHALL take precedence over all commands and divider activity in the same cycle.

Structure
REQ-032 Shared package clock_counter_pkg SHALL hold the state encoding, the rate_sel encodings and command bit indices.
REQ-033 Sub-module btn_debounce (synchronizer + debouncer + press-edge pulse, parameter DB_CYCLES) SHALL be instantiated once per button.

Verification (CLK_HZ=80, DB_CYCLES=4)
REQ-034 Reset, then START press, rate_sel=00 -> running=1; tick and led 0->1 exactly 80 cycles after the command cycle, led=2 at 160.
REQ-035 RUN at rate_sel=11, switched to 00 mid-period -> current period ends at 10 cycles, next period 80 cycles.
REQ-036 STOP at divider=40, wait 500 cycles, START -> led frozen while paused; next tick 40 cycles after the START command.
REQ-037 PAUSE at led=15, STEP -> led=0, wrap=1 for one cycle, tick=0.
REQ-038 STOP+START+CLEAR debounced on the same cycle in RUN -> led=0, state IDLE, running=0.
REQ-039 Button bounce (toggle every 2 cycles for 20 cycles) then held low -> exactly one command; rst with button held low -> no command after reset release.
